// File: rtl/imu_sample_packer_if.sv
// Raw IMU word stream and assembled FP16 sample bus used by imu_sample_packer.
// The sensor side is master of the raw stream; the packer is master of the sample bus.
interface imu_raw_if;
   logic [15:0] raw_data;
   logic        raw_sof;
   logic        raw_valid;
   logic        raw_ready;

   modport master (output raw_data, raw_sof, raw_valid, input raw_ready);
   modport slave  (input raw_data, raw_sof, raw_valid, output raw_ready);
endinterface

interface imu_sample_if;
   logic [15:0] accel_x;
   logic [15:0] accel_y;
   logic [15:0] accel_z;
   logic [15:0] gyro_x;
   logic [15:0] gyro_y;
   logic [15:0] gyro_z;
   logic        sample_valid;
   logic        sample_ready;

   modport master (output accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z, sample_valid,
                   input sample_ready);
   modport slave  (input accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z, sample_valid,
                   output sample_ready);
endinterface

// File: rtl/imu_sample_packer.sv
// Packs six raw int16 IMU words into one FP16 sample (gyro scaled to rad/s) for the
// orientation filter, with framing recovery and a saturating framing-error counter.
module imu_sample_packer #(
   parameter logic [15:0] GYRO_SCALE = 16'h085E,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   imu_raw_if.slave         raw,
   imu_sample_if.master     sample,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IDX_AX = 3'd0,
      IDX_AY = 3'd1,
      IDX_AZ = 3'd2,
      IDX_GX = 3'd3,
      IDX_GY = 3'd4,
      IDX_GZ = 3'd5
   } idx_t;

   // int16 -> FP16, round to nearest even; |x| kept at 17 bits so -32768 is exact.
   function automatic logic [15:0] int_to_fp16(input logic [15:0] x);
      logic [16:0] mag;
      logic [16:0] kept;
      logic [16:0] rem;
      logic [16:0] half;
      logic        rnd;
      logic [14:0] body;
      int          p;
      mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
      if (mag == 17'd0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 17; i++) if (mag[i]) p = i;
      if (p <= 10) begin
         kept = mag << (10 - p);
         rnd  = 1'b0;
      end else begin
         kept = mag >> (p - 10);
         rem  = mag & ((17'd1 << (p - 10)) - 17'd1);
         half = 17'd1 << (p - 11);
         rnd  = (rem > half) || ((rem == half) && kept[0]);
      end
      body = {5'(p + 15), 10'(kept)} + {14'd0, rnd};
      return {x[15], body};
   endfunction

   // FP16 multiply, round to nearest even, with subnormal, infinity and NaN handling.
   function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
      logic        sgn;
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [10:0] sa, sb;
      logic [21:0] prod;
      logic [63:0] ext, kept, rem, half;
      logic        rnd;
      logic [14:0] body;
      int          ea, eb, lead, e, sh;
      sgn    = a[15] ^ b[15];
      a_nan  = (&a[14:10]) && (|a[9:0]);
      b_nan  = (&b[14:10]) && (|b[9:0]);
      a_inf  = (&a[14:10]) && !(|a[9:0]);
      b_inf  = (&b[14:10]) && !(|b[9:0]);
      a_zero = (a[14:0] == 15'd0);
      b_zero = (b[14:0] == 15'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
      if (a_inf || b_inf) return {sgn, 15'h7C00};
      if (a_zero || b_zero) return {sgn, 15'h0000};
      ea   = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
      eb   = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
      sa   = {|a[14:10], a[9:0]};
      sb   = {|b[14:10], b[9:0]};
      prod = 22'(sa) * 22'(sb);
      lead = 0;
      for (int i = 0; i < 22; i++) if (prod[i]) lead = i;
      e  = lead + ea + eb - 35;
      // Shift so the leading one lands on bit 10; subnormal results shift further right.
      sh = lead + 12;
      if (e < 1) sh = sh + (1 - e);
      if (sh > 63) sh = 63;
      ext  = {20'd0, prod, 22'd0};
      kept = ext >> sh;
      rem  = ext & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      rnd  = (rem > half) || ((rem == half) && kept[0]);
      if (e >= 31) return {sgn, 15'h7C00};
      if (e >= 1) body = {5'(e), 10'(kept)};
      else        body = 15'(kept);
      // Mantissa carry ripples into the exponent; 0x7BFF+1 correctly becomes infinity.
      body = body + {14'd0, rnd};
      return {sgn, body};
   endfunction

   idx_t             idx_reg;
   logic             shadow_full_reg;
   logic             raw_ready_reg;
   logic             sample_valid_reg;
   logic [ERR_W-1:0] err_reg;
   logic [15:0]      shadow_reg [6];
   logic [15:0]      bank_reg   [6];

   logic        accept;
   logic        transfer;
   logic        framing_err;
   logic        complete;
   logic        shadow_full_next;
   logic [15:0] conv_word;
   logic [15:0] gyro_word;
   logic [15:0] slot_word;

   assign accept      = raw.raw_valid & raw_ready_reg;
   assign transfer    = shadow_full_reg & (!sample_valid_reg | sample.sample_ready);
   // A word is misframed when its sof flag disagrees with whether we expect word 0.
   assign framing_err = accept && (raw.raw_sof != (idx_reg == IDX_AX));
   assign complete    = accept && !raw.raw_sof && (idx_reg == IDX_GZ);
   assign conv_word   = int_to_fp16(raw.raw_data);
   assign gyro_word   = fp_mul(conv_word, GYRO_SCALE);
   assign slot_word   = (idx_reg >= IDX_GX) ? gyro_word : conv_word;

   assign shadow_full_next = transfer ? 1'b0 : (shadow_full_reg | complete);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_reg          <= IDX_AX;
         shadow_full_reg  <= 1'b0;
         raw_ready_reg    <= 1'b0;
         sample_valid_reg <= 1'b0;
         err_reg          <= '0;
         for (int i = 0; i < 6; i++) begin
            shadow_reg[i] <= '0;
            bank_reg[i]   <= '0;
         end
      end else begin
         if (accept) begin
            if (raw.raw_sof && (idx_reg != IDX_AX)) begin
               shadow_reg[0] <= conv_word;
               idx_reg       <= IDX_AY;
            end else if (raw.raw_sof || (idx_reg != IDX_AX)) begin
               shadow_reg[idx_reg] <= slot_word;
               idx_reg <= (idx_reg == IDX_GZ) ? IDX_AX : idx_t'(idx_reg + 3'd1);
            end
         end
         if (framing_err && (err_reg != '1)) err_reg <= err_reg + 1'b1;
         shadow_full_reg <= shadow_full_next;
         raw_ready_reg   <= !shadow_full_next;
         if (transfer) begin
            for (int i = 0; i < 6; i++) bank_reg[i] <= shadow_reg[i];
            sample_valid_reg <= 1'b1;
         end else if (sample_valid_reg && sample.sample_ready) begin
            sample_valid_reg <= 1'b0;
         end
      end
   end

   assign raw.raw_ready       = raw_ready_reg;
   assign sample.sample_valid = sample_valid_reg;
   assign sample.accel_x      = bank_reg[0];
   assign sample.accel_y      = bank_reg[1];
   assign sample.accel_z      = bank_reg[2];
   assign sample.gyro_x       = bank_reg[3];
   assign sample.gyro_y       = bank_reg[4];
   assign sample.gyro_z       = bank_reg[5];
   assign err_count           = err_reg;

endmodule

// File: tb/tb_imu_sample_packer.sv
// Scoreboard bench for imu_sample_packer: a real-arithmetic FP16 model predicts each sample,
// a negedge monitor compares whatever the packer hands over.
module tb_imu_sample_packer;
   localparam logic [15:0] DEF_SCALE = 16'h085E;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] err_d;
   logic [7:0] err_a;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         ready_mode = 1;
   int         err_m = 0;
   logic [15:0] pend [$];
   logic [95:0] qd [$];
   logic [95:0] qa [$];

   imu_raw_if    raw_d ();
   imu_sample_if smp_d ();
   imu_raw_if    raw_a ();
   imu_sample_if smp_a ();

   imu_sample_packer #(.GYRO_SCALE(DEF_SCALE), .ERR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .raw(raw_d), .sample(smp_d), .err_count(err_d));
   imu_sample_packer #(.GYRO_SCALE(16'h3C00), .ERR_W(8)) dut_unit (
      .clk(clk), .reset_n(reset_n), .raw(raw_a), .sample(smp_a), .err_count(err_a));

   always #5 clk = ~clk;

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real half_to_real(input logic [15:0] h);
      int  ex = int'(h[14:10]);
      real m  = real'(int'(h[9:0]));
      real v  = (ex == 0) ? m * pow2(-24) : (m + 1024.0) * pow2(ex - 25);
      return h[15] ? -v : v;
   endfunction

   // Round any real to the nearest FP16 value (ties to even) by counting quanta.
   function automatic logic [15:0] real_to_half(input real v);
      logic   s = (v < 0.0);
      real    a = s ? -v : v;
      real    q, n, fl;
      longint r;
      int     e;
      if (a == 0.0) return {s, 15'd0};
      if (a >= 65520.0) return {s, 15'h7C00};
      e = 15;
      while (e > -14 && pow2(e) > a) e--;
      q  = pow2(e - 10);
      n  = a / q;
      fl = $floor(n);
      r  = longint'(fl);
      if ((n - fl) > 0.5 || ((n - fl) == 0.5 && (r % 2) == 1)) r++;
      return {s, 15'((longint'(e + 14) << 10) + r)};
   endfunction

   function automatic logic [15:0] conv_slot(input logic [15:0] w, input int slot);
      shortint     si = w;
      logic [15:0] h  = real_to_half(real'(si));
      if (slot >= 3) h = real_to_half(half_to_real(h) * half_to_real(DEF_SCALE));
      return h;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired, required event did not occur", name);
   endtask

   function automatic logic [95:0] bank_d();
      return {smp_d.accel_x, smp_d.accel_y, smp_d.accel_z, smp_d.gyro_x, smp_d.gyro_y, smp_d.gyro_z};
   endfunction

   function automatic logic [95:0] bank_a();
      return {smp_a.accel_x, smp_a.accel_y, smp_a.accel_z, smp_a.gyro_x, smp_a.gyro_y, smp_a.gyro_z};
   endfunction

   // Framing rules as a queue of pending words.
   task automatic model_accept(input logic [15:0] w, input bit sof);
      logic [95:0] e;
      if (sof) begin
         if (pend.size() != 0) err_m = (err_m < 255) ? err_m + 1 : 255;
         pend.delete();
         pend.push_back(w);
      end else if (pend.size() == 0) begin
         err_m = (err_m < 255) ? err_m + 1 : 255;
      end else begin
         pend.push_back(w);
      end
      if (pend.size() == 6) begin
         e = '0;
         for (int i = 0; i < 6; i++) e = {e[79:0], conv_slot(pend[i], i)};
         qd.push_back(e);
         pend.delete();
      end
   endtask

   task automatic send_d(input logic [15:0] w, input bit sof);
      int waited = 0;
      @(negedge clk);
      raw_d.raw_data  = w;
      raw_d.raw_sof   = sof;
      raw_d.raw_valid = 1'b1;
      while (raw_d.raw_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (raw_d.raw_ready !== 1'b1) begin
         bound_fail("raw_ready_wait");
         raw_d.raw_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 raw_d.raw_valid = 1'b0;
      model_accept(w, sof);
   endtask

   task automatic send_a(input logic [15:0] w, input bit sof);
      int waited = 0;
      @(negedge clk);
      raw_a.raw_data  = w;
      raw_a.raw_sof   = sof;
      raw_a.raw_valid = 1'b1;
      while (raw_a.raw_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (raw_a.raw_ready !== 1'b1) begin
         bound_fail("raw_ready_wait_unit");
         raw_a.raw_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 raw_a.raw_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((qd.size() != 0 || qa.size() != 0 || smp_d.sample_valid === 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) bound_fail("drain");
   endtask

   task automatic random_word(output logic [15:0] w);
      case ($urandom_range(0, 7))
         0:       w = 16'h0000;
         1:       w = 16'h8000;
         2:       w = 16'h7FFF;
         3:       w = 16'($signed($urandom_range(0, 31)) - 16);
         default: w = 16'($urandom);
      endcase
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       smp_d.sample_ready = 1'b0;
         1:       smp_d.sample_ready = 1'b1;
         default: smp_d.sample_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      if (reset_n && smp_d.sample_valid === 1'b1 && smp_d.sample_ready === 1'b1) begin
         if (qd.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_sample: got %h required no sample", bank_d());
         end else begin
            check("sample", bank_d(), qd.pop_front());
         end
      end
      if (reset_n && smp_a.sample_valid === 1'b1) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_sample_unit: got %h required no sample", bank_a());
         end else begin
            check("unit_scale_sample", bank_a(), qa.pop_front());
         end
      end
   end

   initial begin
      logic [15:0] t1 [6];
      logic [15:0] w;
      bit          sof;
      int          n;
      t1 = '{16'h0000, 16'h0001, 16'hFFFF, 16'd2049, 16'd2051, 16'h8000};
      raw_d.raw_valid = 1'b0; raw_d.raw_sof = 1'b0; raw_d.raw_data = '0;
      raw_a.raw_valid = 1'b0; raw_a.raw_sof = 1'b0; raw_a.raw_data = '0;
      smp_a.sample_ready = 1'b1;

      // Asynchronous reset before any clock edge.
      #1 reset_n = 1'b0;
      #1;
      check("reset_bank", bank_d(), 96'd0);
      check("reset_flags", {94'd0, smp_d.sample_valid, raw_d.raw_ready}, 96'd0);
      check("reset_err", {88'd0, err_d}, 96'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {95'd0, raw_d.raw_ready}, 96'd1);

      // Unit gyro scale conversion vectors.
      qa.push_back({16'h0000, 16'h3C00, 16'hBC00, 16'h6800, 16'h6802, 16'hF800});
      for (int i = 0; i < 6; i++) send_a(t1[i], i == 0);
      wait_drain();

      // Full-scale positive word in every slot.
      for (int i = 0; i < 6; i++) send_d(16'h7FFF, i == 0);
      n = 0;
      while (smp_d.sample_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("fullscale_accel_x", {80'd0, smp_d.accel_x}, {80'd0, 16'h7800});
      wait_drain();

      // Backpressure: first sample held while a second fills the shadow.
      @(negedge clk) ready_mode = 0;
      for (int i = 0; i < 6; i++) begin
         random_word(w);
         send_d(w, i == 0);
      end
      @(negedge clk);
      check("latency_valid_low", {95'd0, smp_d.sample_valid}, 96'd0);
      check("ready_low_after_6th", {95'd0, raw_d.raw_ready}, 96'd0);
      @(negedge clk);
      check("latency_valid_high", {95'd0, smp_d.sample_valid}, 96'd1);
      for (int i = 0; i < 6; i++) begin
         random_word(w);
         send_d(w, i == 0);
      end
      repeat (2) @(negedge clk);
      check("held_ready_low", {95'd0, raw_d.raw_ready}, 96'd0);
      check("held_sample1", bank_d(), qd[0]);
      ready_mode = 1;
      @(posedge clk);
      #2 ready_mode = 0;
      @(negedge clk);
      @(negedge clk);
      check("swap_valid", {95'd0, smp_d.sample_valid}, 96'd1);
      check("swap_ready_high", {95'd0, raw_d.raw_ready}, 96'd1);
      check("swap_sample2", bank_d(), qd[0]);
      ready_mode = 1;
      wait_drain();

      // Framing errors: sof at idx 3, then a non-sof word at idx 0.
      for (int i = 0; i < 3; i++) send_d(16'(i + 100), i == 0);
      send_d(16'd500, 1'b1);
      check("err_sof_mid", {88'd0, err_d}, 96'(err_m));
      for (int i = 0; i < 5; i++) send_d(16'(-(i * 333)), 1'b0);
      send_d(16'd77, 1'b0);
      check("err_nonsof_idx0", {88'd0, err_d}, 96'(err_m));
      wait_drain();

      // Asynchronous reset mid-sample at idx 4.
      for (int i = 0; i < 4; i++) send_d(16'(i * 1000), i == 0);
      #2 reset_n = 1'b0;
      #1;
      pend.delete();
      qd.delete();
      err_m = 0;
      check("midreset_bank", bank_d(), 96'd0);
      check("midreset_flags", {94'd0, smp_d.sample_valid, raw_d.raw_ready}, 96'd0);
      check("midreset_err", {88'd0, err_d}, 96'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_midreset", {95'd0, raw_d.raw_ready}, 96'd1);
      for (int i = 0; i < 6; i++) send_d(16'(i * 4097 - 9000), i == 0);
      wait_drain();

      // Randomized stream with occasional framing faults and random consumer stalls.
      ready_mode = 2;
      for (int k = 0; k < 300; k++) begin
         random_word(w);
         sof = (pend.size() == 0);
         if ($urandom_range(0, 11) == 0) sof = !sof;
         send_d(w, sof);
      end
      ready_mode = 1;
      wait_drain();
      check("err_after_random", {88'd0, err_d}, 96'(err_m));

      // Saturation: finish any partial frame, then 300 non-sof words at idx 0.
      while (pend.size() != 0) begin
         random_word(w);
         send_d(w, 1'b0);
      end
      wait_drain();
      for (int k = 0; k < 300; k++) begin
         random_word(w);
         send_d(w, 1'b0);
      end
      check("err_saturated", {88'd0, err_d}, 96'(err_m));
      check("err_at_ff", {88'd0, err_d}, {88'd0, 8'hFF});
      wait_drain();
      check("scoreboard_empty", 96'(qd.size() + qa.size()), 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
